// File: rtl/imm_rot_pkg.sv
// imm_rot_pkg: shared types and defaults for the rotated-immediate encoder.
package imm_rot_pkg;
  localparam int IMM_W = 8;
  localparam int ROT_STEPS = 16;
  localparam int ROT_W = $clog2(ROT_STEPS);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;
  typedef struct packed {
    logic             found;
    logic             inv;
    logic [IMM_W-1:0] imm;
    logic [ROT_W-1:0] rot;
  } result_t;
endpackage

// File: rtl/imm_rot_check.sv
// imm_rot_check: tests one rotation; passes when ROL(value, 2*r) fits in IMM_W bits.
module imm_rot_check #(
  parameter int IMM_W = 8,
  parameter int ROT_W = 4
) (
  input  logic [31:0]      value,
  input  logic [ROT_W-1:0] r,
  output logic             pass,
  output logic [IMM_W-1:0] imm
);
  logic [4:0]  sh;
  logic [31:0] cand;
  always_comb begin
    sh = 5'({r, 1'b0});
    cand = (value << sh) | (value >> (6'd32 - {1'b0, sh}));
    pass = cand[31:IMM_W] == '0;
    imm = cand[IMM_W-1:0];
  end
endmodule

// File: rtl/imm_rot_encoder.sv
// imm_rot_encoder: multi-cycle search for an ARM imm8/rot4 encoding of a 32-bit constant.
// IMM_ROT_INVERT_EN additionally searches the complement and flags it on out_inv.
module imm_rot_encoder #(
  parameter int ROT_STEPS = imm_rot_pkg::ROT_STEPS,
  parameter int IMM_W = imm_rot_pkg::IMM_W,
  localparam int ROT_W = $clog2(ROT_STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_found,
  output logic [IMM_W-1:0] out_imm,
  output logic [ROT_W-1:0] out_rot,
  output logic             out_inv
);
  import imm_rot_pkg::*;
  state_e           state_q, state_d;
  logic [31:0]      val_q, val_d;
  logic [ROT_W-1:0] r_q, r_d, rot_q, rot_d;
  logic [IMM_W-1:0] imm_q, imm_d, imm_dir, imm_inv;
  logic             found_q, found_d, inv_q, inv_d, pass_dir, pass_inv;

  imm_rot_check #(.IMM_W(IMM_W), .ROT_W(ROT_W)) u_dir (
    .value(val_q), .r(r_q), .pass(pass_dir), .imm(imm_dir)
  );
`ifdef IMM_ROT_INVERT_EN
  imm_rot_check #(.IMM_W(IMM_W), .ROT_W(ROT_W)) u_inv (
    .value(~val_q), .r(r_q), .pass(pass_inv), .imm(imm_inv)
  );
`else
  assign pass_inv = 1'b0;
  assign imm_inv = '0;
`endif

  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_found = found_q;
  assign out_imm = imm_q;
  assign out_rot = rot_q;
  assign out_inv = inv_q;

  always_comb begin
    state_d = state_q;
    val_d = val_q;
    r_d = r_q;
    found_d = found_q;
    inv_d = inv_q;
    imm_d = imm_q;
    rot_d = rot_q;
    case (state_q)
      IDLE: if (in_valid) begin
        val_d = in_value;
        r_d = '0;
        state_d = SEARCH;
      end
      SEARCH: begin
        // direct match wins over inverted at the same rotation
        if (pass_dir || pass_inv || r_q == ROT_W'(ROT_STEPS - 1)) begin
          found_d = pass_dir || pass_inv;
          inv_d = !pass_dir && pass_inv;
          imm_d = pass_dir ? imm_dir : pass_inv ? imm_inv : '0;
          rot_d = (pass_dir || pass_inv) ? r_q : '0;
          state_d = DONE;
        end else r_d = r_q + 1'b1;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      val_q <= '0;
      r_q <= '0;
      found_q <= 1'b0;
      inv_q <= 1'b0;
      imm_q <= '0;
      rot_q <= '0;
    end else begin
      state_q <= state_d;
      val_q <= val_d;
      r_q <= r_d;
      found_q <= found_d;
      inv_q <= inv_d;
      imm_q <= imm_d;
      rot_q <= rot_d;
    end
  end
endmodule

// File: tb/tb_imm_rot_encoder.sv
// tb_imm_rot_encoder: directed checks of encodings, latency, backpressure and reset abort.
module tb_imm_rot_encoder;
  import imm_rot_pkg::*;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_value = '0;
  logic in_ready, out_valid, out_found, out_inv;
  logic [IMM_W-1:0] out_imm;
  logic [ROT_W-1:0] out_rot;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  imm_rot_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_found(out_found), .out_imm(out_imm), .out_rot(out_rot), .out_inv(out_inv)
  );

  function automatic result_t mk(input logic f, input logic i, input logic [IMM_W-1:0] im,
                                 input logic [ROT_W-1:0] ro);
    mk = {f, i, im, ro};
  endfunction

  function automatic result_t outs();
    outs = {out_found, out_inv, out_imm, out_rot};
  endfunction

  task automatic req(input logic [31:0] v, input result_t exp, input int lat, input int hold,
                     input string name);
    int k;
    @(negedge clk);
    in_valid = 1; in_value = v; out_ready = 0;
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s idle_ready got %b exp 1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s busy_ready got %b exp 0", name, in_ready); end
    k = 1;
    while (out_valid !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    n_chk++;
    if (k !== lat) begin n_fail++; $display("FAIL %s latency got %0d exp %0d", name, k, lat); end
    n_chk++;
    if (outs() !== exp) begin n_fail++; $display("FAIL %s result got %h exp %h", name, outs(), exp); end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; in_value = ~v;
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || outs() !== exp) begin
        n_fail++;
        $display("FAIL %s hold%0d got v=%b r=%b res=%h exp v=1 r=0 res=%h", name, i, out_valid, in_ready, outs(), exp);
      end
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s release got v=%b r=%b exp v=0 r=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    reset = 0; #12;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || outs() !== '0) begin
      n_fail++; $display("FAIL reset got r=%b v=%b res=%h exp r=1 v=0 res=0", in_ready, out_valid, outs());
    end
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release got %b exp 1", in_ready); end
  endtask

  task automatic test_encode;
    req(32'h000000FF, mk(1, 0, 8'hFF, 4'd0), 2, 0, "rot0");
    req(32'hFF000000, mk(1, 0, 8'hFF, 4'd4), 6, 0, "rot4");
    req(32'hF000000F, mk(1, 0, 8'hFF, 4'd2), 4, 0, "rot2");
    req(32'h00000000, mk(1, 0, 8'h00, 4'd0), 2, 0, "zero");
    req(32'h0000AB00, mk(1, 0, 8'hAB, 4'd12), 14, 0, "rot12");
    req(32'h000003FC, mk(1, 0, 8'hFF, 4'd15), 17, 0, "rot15");
    req(32'h00000102, mk(0, 0, 8'h00, 4'd0), 17, 0, "nofit");
  endtask

  task automatic test_invert;
`ifdef IMM_ROT_INVERT_EN
    req(32'hFFFFFF00, mk(1, 1, 8'hFF, 4'd0), 2, 0, "inv_ff");
    req(32'h00FFFFFF, mk(1, 1, 8'hFF, 4'd4), 6, 0, "inv_rot4");
`else
    req(32'hFFFFFF00, mk(0, 0, 8'h00, 4'd0), 17, 0, "inv_ff");
    req(32'h00FFFFFF, mk(0, 0, 8'h00, 4'd0), 17, 0, "inv_rot4");
`endif
  endtask

  task automatic test_backpressure;
    req(32'hFF000000, mk(1, 0, 8'hFF, 4'd4), 6, 5, "bp");
  endtask

  task automatic test_back_to_back;
    int k;
    @(negedge clk);
    in_valid = 1; in_value = 32'h000000FF; out_ready = 1;
    @(posedge clk); #1;
    in_value = 32'hFF000000;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_imm !== 8'hFF) begin
      n_fail++; $display("FAIL b2b_first got v=%b r=%b imm=%h exp v=1 r=0 imm=ff", out_valid, in_ready, out_imm);
    end
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gap got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got %b exp 0", in_ready); end
    k = 1;
    while (out_valid !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    n_chk++;
    if (k !== 6 || outs() !== mk(1, 0, 8'hFF, 4'd4)) begin
      n_fail++; $display("FAIL b2b_second got lat=%0d res=%h exp lat=6 res=%h", k, outs(), mk(1, 0, 8'hFF, 4'd4));
    end
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    in_valid = 1; in_value = 32'h00000102;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || outs() !== '0) begin
      n_fail++; $display("FAIL abort_search got r=%b v=%b res=%h exp r=1 v=0 res=0", in_ready, out_valid, outs());
    end
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_after got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1; in_value = 32'hF000000F;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_imm !== 8'hFF) begin
      n_fail++; $display("FAIL abort_pre got v=%b imm=%h exp v=1 imm=ff", out_valid, out_imm);
    end
    reset = 0;
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || outs() !== '0) begin
      n_fail++; $display("FAIL abort_done got r=%b v=%b res=%h exp r=1 v=0 res=0", in_ready, out_valid, outs());
    end
    @(negedge clk); reset = 1;
    req(32'h000000FF, mk(1, 0, 8'hFF, 4'd0), 2, 0, "post_abort");
  endtask

  initial begin
    test_reset();
    test_encode();
    test_invert();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
